// File: rtl/mult_div_pkg.sv
// Shared types and op-decoding helpers for the sequential multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_abs.sv
// Two's-complement magnitude of a WIDTH-bit operand; treated as unsigned
// (neg_o=0, value passed through) when signed_i is low.
module md_abs
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  assign neg_o = signed_i & val_i[WIDTH-1];
  assign mag_o = neg_o ? -val_i : val_i;

endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle signed/unsigned MULT/DIV for the HI/LO pair: Booth multiply, restoring divide.
// Optional zero/small-operand shortcut enabled by defining MULT_DIV_EARLY_OUT_EN.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  op_t              op_in;
  logic             in_div;
  logic             in_signed;
  logic             accept;
  logic             div_by_zero;
  logic             early_out;
  logic [WIDTH-1:0] early_hi;

  logic [WIDTH-1:0] opnd [2];
  logic [WIDTH-1:0] mag  [2];
  logic             neg  [2];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_step;
  logic             is_div_q;
  logic             corr_q;
  logic             sign_a_q;
  logic             sign_q_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH+1:0] mcand_q, acc_q, booth_sum, acc_nx;
  logic [WIDTH-1:0] mplr_q, mplr_nx;
  logic             qm1_q;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_nx, quo_nx, rem_diff;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  assign op_in       = op_t'(op);
  assign in_div      = op_is_div(op_in);
  assign in_signed   = op_is_signed(op_in);
  assign accept      = start && !busy;
  assign div_by_zero = in_div && (b == '0);
  assign opnd[0]     = a;
  assign opnd[1]     = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      md_abs #(.WIDTH(WIDTH)) u_abs (
        .val_i    (opnd[gi]),
        .signed_i (in_signed),
        .mag_o    (mag[gi]),
        .neg_o    (neg[gi])
      );
    end
  endgenerate

`ifdef MULT_DIV_EARLY_OUT_EN
  // A zero factor or a dividend smaller than the divisor has a trivial result.
  assign early_out = in_div ? (mag[0] < mag[1]) : ((a == '0) || (b == '0));
  assign early_hi  = in_div ? a : '0;
`else
  assign early_out = 1'b0;
  assign early_hi  = '0;
`endif

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Booth step: add/subtract the multiplicand, then arithmetic shift of {acc, mplr}.
  always_comb begin
    booth_sum = acc_q;
    case ({mplr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_q;
      2'b10:   booth_sum = acc_q - mcand_q;
      default: booth_sum = acc_q;
    endcase
  end

  assign acc_nx  = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
  assign mplr_nx = {booth_sum[0], mplr_q[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, dvs_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - dvs_q;
  assign rem_nx   = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
  assign quo_nx   = {quo_q[WIDTH-2:0], rem_ge};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = (div_by_zero || early_out) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = is_div_q ? FIX : DONE;
        end
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN, FIX: busy = 1'b1;
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      corr_q     <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_q_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplr_q     <= '0;
      qm1_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            cnt_q      <= '0;
            div_zero_q <= div_by_zero;
            is_div_q   <= in_div;
            corr_q     <= !in_signed && b[WIDTH-1];
            sign_a_q   <= neg[0];
            sign_q_q   <= neg[0] ^ neg[1];
            mcand_q    <= in_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            acc_q      <= '0;
            mplr_q     <= b;
            qm1_q      <= 1'b0;
            rem_q      <= '0;
            quo_q      <= mag[0];
            dvs_q      <= mag[1];
            if (early_out) begin
              hi_q <= early_hi;
              lo_q <= '0;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
          end else begin
            acc_q  <= acc_nx;
            mplr_q <= mplr_nx;
            qm1_q  <= mplr_q[0];
            // The (W+1)th Booth step over a zero-extended multiplier only ever adds M<<W.
            if (last_step) begin
              hi_q <= acc_nx[WIDTH-1:0] + (corr_q ? mcand_q[WIDTH-1:0] : '0);
              lo_q <= mplr_nx;
            end
          end
        end
        FIX: begin
          hi_q <= sign_a_q ? -rem_q : rem_q;
          lo_q <= sign_q_q ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
